// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared decode definitions for the ID-stage control unit:
// opcodes, function codes, ALU enums and the ID/EX control word.
package pipe_ctrl_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_STOP  = 6'd63;

  localparam logic [5:0] F_SLL  = 6'd0;
  localparam logic [5:0] F_SRL  = 6'd2;
  localparam logic [5:0] F_SRA  = 6'd3;
  localparam logic [5:0] F_SLLV = 6'd4;
  localparam logic [5:0] F_SRLV = 6'd6;
  localparam logic [5:0] F_SRAV = 6'd7;
  localparam logic [5:0] F_JR   = 6'd8;
  localparam logic [5:0] F_ADD  = 6'd32;
  localparam logic [5:0] F_ADDU = 6'd33;
  localparam logic [5:0] F_SUB  = 6'd34;
  localparam logic [5:0] F_SUBU = 6'd35;
  localparam logic [5:0] F_AND  = 6'd36;
  localparam logic [5:0] F_OR   = 6'd37;
  localparam logic [5:0] F_XOR  = 6'd38;
  localparam logic [5:0] F_NOR  = 6'd39;
  localparam logic [5:0] F_SLT  = 6'd42;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,
    ALU_SUB = 5'd1,
    ALU_AND = 5'd2,
    ALU_OR  = 5'd3,
    ALU_XOR = 5'd4,
    ALU_NOR = 5'd5,
    ALU_SLT = 5'd6,
    ALU_SLL = 5'd7,
    ALU_SRL = 5'd8,
    ALU_SRA = 5'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    SRC_REG   = 3'd0,
    SRC_ZIMM  = 3'd1,
    SRC_SIMM  = 3'd2,
    SRC_RSAMT = 3'd3,
    SRC_SHAMT = 3'd4
  } alu_src_e;

  typedef struct packed {
    logic       reg_we;
    logic       mem2reg;
    logic       mem_we;
    logic       beq;
    logic       bne;
    logic       jump;
    logic       jump_reg;
    logic       link;
    alu_op_e    alu_ctrl;
    alu_src_e   alu_src;
    logic [4:0] wr_reg;
  } ctrl_word_t;

  localparam ctrl_word_t BUBBLE = ctrl_word_t'('0);

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational main decoder: opcode/func to control word,
// plus register-use flags for hazard detection.
module ctrl_decode
  import pipe_ctrl_unit_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  func_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  output ctrl_word_t  ctrl_o,
  output logic        uses_rs_o,
  output logic        uses_rt_o,
  output logic        is_stop_o,
  output logic        is_illegal_o
);

  always_comb begin
    ctrl_o       = BUBBLE;
    uses_rs_o    = 1'b1;
    uses_rt_o    = 1'b0;
    is_stop_o    = 1'b0;
    is_illegal_o = 1'b0;
    unique case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.reg_we = 1'b1;
        ctrl_o.wr_reg = rd_i;
        uses_rt_o     = (func_i != F_JR);
        unique case (func_i)
          F_SLL: begin
            ctrl_o.alu_ctrl = ALU_SLL;
            ctrl_o.alu_src  = SRC_SHAMT;
            uses_rs_o       = 1'b0;
          end
          F_SRL: begin
            ctrl_o.alu_ctrl = ALU_SRL;
            ctrl_o.alu_src  = SRC_SHAMT;
            uses_rs_o       = 1'b0;
          end
          F_SRA: begin
            ctrl_o.alu_ctrl = ALU_SRA;
            ctrl_o.alu_src  = SRC_SHAMT;
            uses_rs_o       = 1'b0;
          end
          F_SLLV: begin
            ctrl_o.alu_ctrl = ALU_SLL;
            ctrl_o.alu_src  = SRC_RSAMT;
          end
          F_SRLV: begin
            ctrl_o.alu_ctrl = ALU_SRL;
            ctrl_o.alu_src  = SRC_RSAMT;
          end
          F_SRAV: begin
            ctrl_o.alu_ctrl = ALU_SRA;
            ctrl_o.alu_src  = SRC_RSAMT;
          end
          F_JR: begin
            ctrl_o.jump_reg = 1'b1;
            ctrl_o.reg_we   = 1'b0;
          end
          F_ADD, F_ADDU: ctrl_o.alu_ctrl = ALU_ADD;
          F_SUB, F_SUBU: ctrl_o.alu_ctrl = ALU_SUB;
          F_AND:         ctrl_o.alu_ctrl = ALU_AND;
          F_OR:          ctrl_o.alu_ctrl = ALU_OR;
          F_XOR:         ctrl_o.alu_ctrl = ALU_XOR;
          F_NOR:         ctrl_o.alu_ctrl = ALU_NOR;
          F_SLT:         ctrl_o.alu_ctrl = ALU_SLT;
          default:       is_illegal_o    = 1'b1;
        endcase
      end
      OP_J: begin
        ctrl_o.jump = 1'b1;
        uses_rs_o   = 1'b0;
      end
      OP_JAL: begin
        ctrl_o.jump   = 1'b1;
        ctrl_o.link   = 1'b1;
        ctrl_o.reg_we = 1'b1;
        ctrl_o.wr_reg = LINK_REG;
        uses_rs_o     = 1'b0;
      end
      OP_BEQ, OP_BNE: begin
        ctrl_o.beq      = (opcode_i == OP_BEQ);
        ctrl_o.bne      = (opcode_i == OP_BNE);
        ctrl_o.alu_ctrl = ALU_SUB;
        ctrl_o.wr_reg   = rt_i;
        uses_rt_o       = 1'b1;
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl_o.reg_we  = 1'b1;
        ctrl_o.alu_src = SRC_SIMM;
        ctrl_o.wr_reg  = rt_i;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl_o.reg_we   = 1'b1;
        ctrl_o.alu_src  = SRC_ZIMM;
        ctrl_o.wr_reg   = rt_i;
        ctrl_o.alu_ctrl = (opcode_i == OP_ANDI) ? ALU_AND :
                          (opcode_i == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_LW: begin
        ctrl_o.reg_we  = 1'b1;
        ctrl_o.mem2reg = 1'b1;
        ctrl_o.alu_src = SRC_SIMM;
        ctrl_o.wr_reg  = rt_i;
      end
      OP_SW: begin
        ctrl_o.mem_we  = 1'b1;
        ctrl_o.alu_src = SRC_SIMM;
        ctrl_o.wr_reg  = rt_i;
        uses_rt_o      = 1'b1;
      end
      OP_STOP: is_stop_o    = 1'b1;
      default: is_illegal_o = 1'b1;
    endcase
    if (is_illegal_o || is_stop_o) ctrl_o = BUBBLE;
    // r0 is hardwired, so a write to it is dropped here
    if (ctrl_o.wr_reg == 5'd0) ctrl_o.reg_we = 1'b0;
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID-stage control: registered decode into ID/EX, load-use
// stall, flush/illegal bubbles and the STOP drain/halt FSM.
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int ALUC_W       = 5,
  parameter int SRC_W        = 3,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [31:0]       id_instr_i,
  input  logic              br_taken_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic              ex_reg_we_o,
  output logic              ex_mem2reg_o,
  output logic              ex_mem_we_o,
  output logic              ex_beq_o,
  output logic              ex_bne_o,
  output logic              ex_jump_o,
  output logic              ex_jump_reg_o,
  output logic              ex_link_o,
  output logic [ALUC_W-1:0] ex_alu_ctrl_o,
  output logic [SRC_W-1:0]  ex_alu_src_o,
  output logic [4:0]        ex_wr_reg_o,
  output logic              halted_o,
  output logic              illegal_o
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALT
  } state_e;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_e     state_q;
  logic [3:0] cnt_q;
  ctrl_word_t ctrl_q, ctrl_d;
  logic       valid_q, valid_d;
  logic       illegal_q;

  ctrl_word_t dec;
  logic       uses_rs, uses_rt, is_stop, is_ill;
  logic       hazard, run, go_stop, set_ill;
  logic [4:0] rs, rt;
  logic       unused_shamt;

  assign rs           = id_instr_i[25:21];
  assign rt           = id_instr_i[20:16];
  assign unused_shamt = ^id_instr_i[10:6];

  ctrl_decode u_dec (
    .opcode_i     (id_instr_i[31:26]),
    .func_i       (id_instr_i[5:0]),
    .rt_i         (rt),
    .rd_i         (id_instr_i[15:11]),
    .ctrl_o       (dec),
    .uses_rs_o    (uses_rs),
    .uses_rt_o    (uses_rt),
    .is_stop_o    (is_stop),
    .is_illegal_o (is_ill)
  );

  assign hazard = valid_q && ctrl_q.mem2reg
               && (ctrl_q.wr_reg != 5'd0)
               && ((uses_rs && (rs == ctrl_q.wr_reg))
                || (uses_rt && (rt == ctrl_q.wr_reg)));

  assign run     = (state_q == S_RUN);
  assign stall_o = !run || (hazard && !br_taken_i);

  always_comb begin
    ctrl_d  = BUBBLE;
    valid_d = 1'b0;
    go_stop = 1'b0;
    set_ill = 1'b0;
    if (run && !br_taken_i && !hazard && id_valid_i) begin
      unique case (1'b1)
        is_ill:  set_ill = 1'b1;
        is_stop: go_stop = 1'b1;
        default: begin
          ctrl_d  = dec;
          valid_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RUN;
      cnt_q     <= 4'd0;
      ctrl_q    <= BUBBLE;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      if (set_ill) illegal_q <= 1'b1;
      unique case (state_q)
        S_RUN: begin
          if (go_stop) begin
            if (DRAIN_CYCLES <= 1) begin
              state_q <= S_HALT;
            end else begin
              state_q <= S_DRAIN;
              cnt_q   <= DRAIN_INIT;
            end
          end
        end
        S_DRAIN: begin
          // counter hits 1 on this edge
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd2) state_q <= S_HALT;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign ex_valid_o    = valid_q;
  assign ex_reg_we_o   = ctrl_q.reg_we;
  assign ex_mem2reg_o  = ctrl_q.mem2reg;
  assign ex_mem_we_o   = ctrl_q.mem_we;
  assign ex_beq_o      = ctrl_q.beq;
  assign ex_bne_o      = ctrl_q.bne;
  assign ex_jump_o     = ctrl_q.jump;
  assign ex_jump_reg_o = ctrl_q.jump_reg;
  assign ex_link_o     = ctrl_q.link;
  assign ex_alu_ctrl_o = ALUC_W'(ctrl_q.alu_ctrl);
  assign ex_alu_src_o  = SRC_W'(ctrl_q.alu_src);
  assign ex_wr_reg_o   = ctrl_q.wr_reg;
  assign halted_o      = (state_q == S_HALT);
  assign illegal_o     = illegal_q;

endmodule
